// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//
// Purpose:
//   Sequences single commands through an external combinational 4-bit ALU.
//   It holds a 4 x 4-bit register file (r0-r3) and a sticky carry flag.
//   The handshake is valid/ready on both the command side and the result side.
//   Each command goes IDLE -> EXEC -> RESP -> IDLE.
//   EXEC is a single settle cycle for the external ALU.
//   RESP holds the result until the consumer takes it.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset
//   cmd_valid  command present
//   cmd_ready  block can accept a command (registered, high only in IDLE)
//   cmd_op     opcode: 0-13 ALU ops, 14 LOADI, 15 READ
//   cmd_rd     destination register index
//   cmd_rs1    first source register index
//   cmd_rs2    second source register index
//   cmd_imm    immediate value for LOADI
//   alu_a      operand A to the external ALU (held between acceptances)
//   alu_b      operand B to the external ALU (held between acceptances)
//   alu_s      operation select to the external ALU (held between acceptances)
//   alu_y      ALU result
//   alu_cout   ALU carry / shift-out
//   res_valid  result present (high only in RESP)
//   res_ready  consumer can take the result
//   res_data   result value
//   res_cout   result carry (ALU ops only, zero otherwise)
//   c_flag     sticky carry of the last completed ALU op
// ---------------------------------------------------------------------------
module alu_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [1:0] cmd_rd,
    input  logic [1:0] cmd_rs1,
    input  logic [1:0] cmd_rs2,
    input  logic [3:0] cmd_imm,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_s,
    input  logic [3:0] alu_y,
    input  logic       alu_cout,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_data,
    output logic       res_cout,
    output logic       c_flag
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_LOADI = 4'hE;
    localparam logic [3:0] OP_READ  = 4'hF;

    state_t     state;
    logic [3:0] regs [4];
    logic [3:0] op_q;
    logic [3:0] imm_q;
    logic [1:0] rd_q;

    // Single FSM process. It owns every piece of state, so all outputs are
    // registered. The register file and c_flag are written only on the
    // EXEC->RESP edge. Reset is checked first, so a reset in EXEC or RESP
    // drops the command without any writeback.
    // Sources are captured into alu_a/alu_b at acceptance. This makes
    // rd == rs1/rs2 safe, and lets READ return the captured alu_a value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_cout  <= 1'b0;
            c_flag    <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s     <= '0;
            op_q      <= '0;
            imm_q     <= '0;
            rd_q      <= '0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        alu_a     <= regs[cmd_rs1];
                        alu_b     <= regs[cmd_rs2];
                        alu_s     <= cmd_op;
                        op_q      <= cmd_op;
                        rd_q      <= cmd_rd;
                        imm_q     <= cmd_imm;
                        cmd_ready <= 1'b0;
                        state     <= EXEC;
                    end
                end

                EXEC: begin
                    case (op_q)
                        OP_LOADI: begin
                            res_data   <= imm_q;
                            res_cout   <= 1'b0;
                            regs[rd_q] <= imm_q;
                        end
                        OP_READ: begin
                            res_data <= alu_a;
                            res_cout <= 1'b0;
                        end
                        default: begin
                            res_data   <= alu_y;
                            res_cout   <= alu_cout;
                            regs[rd_q] <= alu_y;
                            c_flag     <= alu_cout;
                        end
                    endcase
                    res_valid <= 1'b1;
                    state     <= RESP;
                end

                RESP: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    res_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
